// File: rtl/alu_src2_decode_stage_pkg.sv
// Shared definitions for the ALU source-2 decode stage.
//   MATCH_LIST_DEF  : default match list; pattern 0 sits in the low 5 bits.
//   HALT_OPCODE_DEF : opcode that starts the drain/halt sequence.
//   state_t         : control state encoding.
package alu_src2_decode_stage_pkg;

   localparam logic [29:0] MATCH_LIST_DEF =
      {5'b11111, 5'b11110, 5'b11101, 5'b11100, 5'b11010, 5'b11011};

   localparam logic [4:0] HALT_OPCODE_DEF = 5'b00000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/alu_src2_decode_stage_opcode_match_vec.sv
// Combinational compare of one opcode against a packed list of patterns.
//   i_opcode : opcode to test
//   o_any    : 1 when any pattern equals i_opcode
//   o_idx    : lowest matching pattern index, 0 when nothing matches
module opcode_match_vec
   import alu_src2_decode_stage_pkg::*;
#(
   parameter int OPCODE_W  = 5,
   parameter int NUM_MATCH = 6,
   parameter int IDX_W     = (NUM_MATCH > 1) ? $clog2(NUM_MATCH) : 1,
   parameter logic [NUM_MATCH*OPCODE_W-1:0] MATCH_LIST = MATCH_LIST_DEF
) (
   input  logic [OPCODE_W-1:0] i_opcode,
   output logic                o_any,
   output logic [IDX_W-1:0]    o_idx
);

   // Scan from the top down so the lowest matching index is written last.
   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      for (int i = NUM_MATCH - 1; i >= 0; i--) begin
         if (i_opcode == MATCH_LIST[i*OPCODE_W +: OPCODE_W]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_src2_decode_stage.sv
// Registered ALU source-2 decode stage, valid/ready elastic, 1 or 2 deep.
//   i_clk, i_rst            : clock, async active-high reset
//   i_in_valid/o_in_ready   : upstream handshake, i_in_opcode payload
//   i_flush                 : drop every in-flight entry
//   i_resume                : leave HALTED
//   o_out_valid/i_out_ready : downstream handshake
//   o_out_opcode, o_out_alu_src2, o_out_match_idx : decoded entry
//   o_halted                : HALTED state flag
//   o_src2_count            : saturating count of alu_src2 output transfers
module alu_src2_decode_stage
   import alu_src2_decode_stage_pkg::*;
#(
   parameter int OPCODE_W   = 5,
   parameter int NUM_MATCH  = 6,
   parameter logic [NUM_MATCH*OPCODE_W-1:0] MATCH_LIST = MATCH_LIST_DEF,
   parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
   parameter int PIPE_DEPTH = 1,
   parameter int CNT_W      = 16,
   localparam int IDX_W     = (NUM_MATCH > 1) ? $clog2(NUM_MATCH) : 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [OPCODE_W-1:0] i_in_opcode,
   input  logic                i_flush,
   input  logic                i_resume,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [OPCODE_W-1:0] o_out_opcode,
   output logic                o_out_alu_src2,
   output logic [IDX_W-1:0]    o_out_match_idx,
   output logic                o_halted,
   output logic [CNT_W-1:0]    o_src2_count
);

   localparam int D = PIPE_DEPTH;

   logic                              w_any;
   logic [IDX_W-1:0]                  w_idx;
   logic                              w_acc;
   logic                              w_out_xfer;
   logic [D-1:0]                      w_rdy;

   // Per-stage sources: element 0 is the decoder input, element k is stage k-1.
   logic [D:0]                        w_src_vld;
   logic [D:0]                        w_src_src2;
   logic [D:0][OPCODE_W-1:0]          w_src_op;
   logic [D:0][IDX_W-1:0]             w_src_idx;

   logic [D-1:0]                      r_vld;
   logic [D-1:0]                      r_src2;
   logic [D-1:0][OPCODE_W-1:0]        r_op;
   logic [D-1:0][IDX_W-1:0]           r_idx;
   state_t                            r_state;
   logic                              r_halted;
   logic [CNT_W-1:0]                  r_cnt;

   opcode_match_vec #(
      .OPCODE_W   (OPCODE_W),
      .NUM_MATCH  (NUM_MATCH),
      .IDX_W      (IDX_W),
      .MATCH_LIST (MATCH_LIST)
   ) u_match (
      .i_opcode (i_in_opcode),
      .o_any    (w_any),
      .o_idx    (w_idx)
   );

   // A stage can load when any stage from it to the output is empty, or the
   // output is being taken; unrolled so the ready chain has no self-loop.
   always_comb begin
      for (int k = 0; k < D; k++) begin
         w_rdy[k] = i_out_ready;
         for (int j = k; j < D; j++) begin
            if (!r_vld[j]) w_rdy[k] = 1'b1;
         end
      end
   end

   assign o_in_ready = w_rdy[0] && (r_state == ST_RUN) && !i_flush;
   assign w_acc      = i_in_valid && o_in_ready;
   assign w_out_xfer = r_vld[D-1] && i_out_ready;

   assign w_src_vld  = {r_vld, w_acc};
   assign w_src_src2 = {r_src2, w_any};
   assign w_src_op   = {r_op, i_in_opcode};
   assign w_src_idx  = {r_idx, w_idx};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vld  <= '0;
         r_src2 <= '0;
         r_op   <= '0;
         r_idx  <= '0;
      end else if (i_flush) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < D; k++) begin
            if (w_rdy[k]) begin
               r_vld[k] <= w_src_vld[k];
               // Payload only moves with a valid entry so outputs stay put
               // once the pipe drains.
               if (w_src_vld[k]) begin
                  r_op[k]   <= w_src_op[k];
                  r_src2[k] <= w_src_src2[k];
                  r_idx[k]  <= w_src_idx[k];
               end
            end
         end
      end
   end

   // Only one halt entry can be in flight: accepting it closes the input.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= ST_RUN;
         r_halted <= 1'b0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_acc && (i_in_opcode == HALT_OPCODE)) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (i_flush) begin
                  r_state <= ST_RUN;
               end else if (w_out_xfer && (r_op[D-1] == HALT_OPCODE)) begin
                  r_state  <= ST_HALTED;
                  r_halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (i_resume) begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_RUN;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                          r_cnt <= '0;
      else if (w_out_xfer && r_src2[D-1] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
   end

   assign o_out_valid     = r_vld[D-1];
   assign o_out_opcode    = r_op[D-1];
   assign o_out_alu_src2  = r_src2[D-1];
   assign o_out_match_idx = r_idx[D-1];
   assign o_halted        = r_halted;
   assign o_src2_count    = r_cnt;

endmodule

// File: tb/tb_alu_src2_decode_stage.sv
module tb_alu_src2_decode_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [4:0] in_opcode = '0;
   logic       flush = 1'b0;
   logic       resume = 1'b0;
   logic       out_ready = 1'b0;

   // a: 1-deep, 2-bit counter   b: 2-deep, 16-bit counter
   logic        a_in_ready, a_out_valid, a_out_src2, a_halted;
   logic [4:0]  a_out_op;
   logic [2:0]  a_out_idx;
   logic [1:0]  a_cnt;
   logic        b_in_ready, b_out_valid, b_out_src2, b_halted;
   logic [4:0]  b_out_op;
   logic [2:0]  b_out_idx;
   logic [15:0] b_cnt;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_src2_decode_stage #(.PIPE_DEPTH(1), .CNT_W(2)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(a_in_ready),
      .i_in_opcode(in_opcode), .i_flush(flush), .i_resume(resume),
      .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_opcode(a_out_op),
      .o_out_alu_src2(a_out_src2), .o_out_match_idx(a_out_idx),
      .o_halted(a_halted), .o_src2_count(a_cnt));

   alu_src2_decode_stage #(.PIPE_DEPTH(2), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
      .i_in_opcode(in_opcode), .i_flush(flush), .i_resume(resume),
      .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_opcode(b_out_op),
      .o_out_alu_src2(b_out_src2), .o_out_match_idx(b_out_idx),
      .o_halted(b_halted), .o_src2_count(b_cnt));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_opcode = '0; flush = 1'b0;
      resume = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // ---- reset state
      do_reset();
      chk("rst_vld",   a_out_valid, 0);
      chk("rst_op",    a_out_op, 0);
      chk("rst_src2",  a_out_src2, 0);
      chk("rst_idx",   a_out_idx, 0);
      chk("rst_halt",  a_halted, 0);
      chk("rst_cnt",   a_cnt, 0);
      chk("rst_rdy",   a_in_ready, 1);
      chk("rst_rdy_b", b_in_ready, 1);

      // ---- stream, depth 1
      out_ready = 1'b1; in_valid = 1'b1; in_opcode = 5'b11011;
      tick();
      chk("s1_vld",  a_out_valid, 1);
      chk("s1_op",   a_out_op, 5'b11011);
      chk("s1_src2", a_out_src2, 1);
      chk("s1_idx",  a_out_idx, 0);
      in_opcode = 5'b11111;
      tick();
      chk("s2_vld",  a_out_valid, 1);
      chk("s2_src2", a_out_src2, 1);
      chk("s2_idx",  a_out_idx, 5);
      in_opcode = 5'b00101;
      tick();
      chk("s3_vld",  a_out_valid, 1);
      chk("s3_src2", a_out_src2, 0);
      chk("s3_idx",  a_out_idx, 0);
      chk("s3_cnt",  a_cnt, 2);
      in_valid = 1'b0;
      tick();
      chk("s4_vld",  a_out_valid, 0);
      chk("s4_cnt",  a_cnt, 2);

      // ---- stall, depth 2
      do_reset();
      in_valid = 1'b1; in_opcode = 5'b11101;
      #1 chk("st_rdy0", b_in_ready, 1);
      tick();
      in_opcode = 5'b11100;
      #1 chk("st_rdy1", b_in_ready, 1);
      tick();
      in_opcode = 5'b11010;
      #1 chk("st_rdy2", b_in_ready, 0);
      chk("st_vld", b_out_valid, 1);
      tick(); tick();
      chk("st_rdy4", b_in_ready, 0);
      chk("st_hold_op",   b_out_op, 5'b11101);
      chk("st_hold_idx",  b_out_idx, 3);
      chk("st_hold_src2", b_out_src2, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("st_o2_vld", b_out_valid, 1);
      chk("st_o2_op",  b_out_op, 5'b11100);
      chk("st_o2_idx", b_out_idx, 2);
      tick();
      chk("st_empty", b_out_valid, 0);
      chk("st_cnt",   b_cnt, 2);

      // ---- halt / resume, depth 1
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_opcode = 5'b00000;
      tick();
      chk("h_vld",  a_out_valid, 1);
      chk("h_src2", a_out_src2, 0);
      in_opcode = 5'b11100;
      #1 chk("h_rdy_drain", a_in_ready, 0);
      chk("h_not_yet", a_halted, 0);
      tick();
      chk("h_halted", a_halted, 1);
      chk("h_empty",  a_out_valid, 0);
      chk("h_rdy",    a_in_ready, 0);
      tick(); tick();
      chk("h_still",  a_halted, 1);
      chk("h_rdy2",   a_in_ready, 0);
      resume = 1'b1;
      #1 chk("h_rdy_res", a_in_ready, 0);
      tick();
      resume = 1'b0;
      chk("h_resumed", a_halted, 0);
      #1 chk("h_rdy_run", a_in_ready, 1);
      tick();
      chk("h_acc_vld", a_out_valid, 1);
      chk("h_acc_op",  a_out_op, 5'b11100);
      chk("h_acc_idx", a_out_idx, 2);
      in_valid = 1'b0;

      // ---- flush, depth 2
      do_reset();
      in_valid = 1'b1; in_opcode = 5'b11111;
      tick();
      in_opcode = 5'b11110;
      tick();
      chk("f_full", b_out_valid, 1);
      flush = 1'b1; in_opcode = 5'b11101;
      #1 chk("f_rdy", b_in_ready, 0);
      tick();
      chk("f_vld", b_out_valid, 0);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk("f_noacc", b_out_valid, 0);
      chk("f_cnt0",  b_cnt, 0);
      in_valid = 1'b1; in_opcode = 5'b11111;
      tick();
      in_opcode = 5'b11110;
      tick();
      flush = 1'b1; out_ready = 1'b1; in_opcode = 5'b11101;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("f2_vld", b_out_valid, 0);
      chk("f2_cnt", b_cnt, 1);
      tick();
      chk("f2_noacc", b_out_valid, 0);

      // ---- counter saturation
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_opcode = 5'b11010;
      repeat (5) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("sat_a", a_cnt, 3);
      chk("sat_b", b_cnt, 5);

      // ---- reset during drain
      do_reset();
      in_valid = 1'b1; in_opcode = 5'b00000;
      tick();
      in_valid = 1'b0;
      chk("r_vld_pre", a_out_valid, 1);
      chk("r_rdy_pre", a_in_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("r_vld", a_out_valid, 0);
      chk("r_op",  a_out_op, 0);
      chk("r_hlt", a_halted, 0);
      chk("r_vld_b", b_out_valid, 0);
      tick();
      rst = 1'b0;
      #1 chk("r_rdy", a_in_ready, 1);
      in_valid = 1'b1; in_opcode = 5'b11100; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("r_run_vld", a_out_valid, 1);
      chk("r_run_op",  a_out_op, 5'b11100);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_src2_decode_stage.md
Name: alu_src2_decode_stage

Overview:
- Parametrised, registered successor to the combinational ALU-source-2 opcode decoder.
- Sits between fetch/decode and execute as an elastic valid/ready stage, 1 or 2 registers deep.
- Compares each accepted opcode against a configurable match list and produces alu_src2 and the index of the matching pattern.
- Adds flush, halt/resume control and a saturating count of transfers that had alu_src2 asserted.

Parameters:
- OPCODE_W, 5, opcode width in bits.
- NUM_MATCH, 6, number of match patterns (at least 1).
- MATCH_LIST, {5'b11111,5'b11110,5'b11101,5'b11100,5'b11010,5'b11011}, packed NUM_MATCH*OPCODE_W vector; pattern i is bits [i*OPCODE_W +: OPCODE_W], so pattern 0 = 5'b11011.
- HALT_OPCODE, 5'b00000, opcode that triggers the halt sequence.
- PIPE_DEPTH, 1, number of register stages, 1 or 2.
- CNT_W, 16, width of the alu_src2 transfer counter.

Ports:
- clk  in  1  clock; all state is captured on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream opcode is valid.
- in_ready  out  1  stage accepts in_opcode this cycle.
- in_opcode  in  OPCODE_W  opcode to decode.
- flush  in  1  discard all in-flight entries.
- resume  in  1  leave the HALTED state.
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream accepts the output entry.
- out_opcode  out  OPCODE_W  opcode passed through.
- out_alu_src2  out  1  opcode matched any pattern.
- out_match_idx  out  max(1,$clog2(NUM_MATCH))  lowest matching pattern index; 0 when no pattern matches.
- halted  out  1  state is HALTED.
- src2_count  out  CNT_W  saturating count of output transfers with out_alu_src2=1.

Behaviour:
- Reset (asynchronous, active-high): all stage valids=0, state=RUN, src2_count=0, out_opcode=0, out_alu_src2=0, out_match_idx=0, halted=0. in_ready=1 once rst deasserts.
- Decode:
  - Combinational on in_opcode; the result is captured with the opcode.
  - alu_src2 = OR over i of (in_opcode == pattern i).
  - match_idx = lowest i that matches.
  - Duplicate patterns are legal; the lowest index wins.
- Pipeline:
  - Each stage k holds {valid, opcode, alu_src2, idx}.
  - Stage ready_k = !valid_k || ready_(k+1); the last stage uses out_ready.
  - Latency: PIPE_DEPTH cycles from acceptance to out_valid when not stalled.
  - Full throughput of 1 per cycle under continuous out_ready.
  - While stalled, stage contents hold stable; out_* do not change while out_valid && !out_ready.
- in_ready = ready_0 && state==RUN && !flush.
- Transfer at the input when in_valid && in_ready; transfer at the output when out_valid && out_ready.
- State machine:
  - RUN:
    - Accepting HALT_OPCODE moves to DRAIN. The halt entry itself flows through.
  - DRAIN:
    - in_ready=0.
    - When the halt entry completes its output transfer -> HALTED.
    - flush -> RUN.
  - HALTED:
    - in_ready=0, halted=1, pipeline empty.
    - resume -> RUN on the next edge; halted drops the same edge.
    - flush has no effect in HALTED.
- Flush:
  - All stage valids clear on the next edge.
  - No input is accepted in the flush cycle.
  - An output transfer in the flush cycle still counts if out_valid && out_ready && out_alu_src2.
  - Flush wins over acceptance.
- src2_count:
  - Increments by 1 on each output transfer with out_alu_src2=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Simultaneous accept and output in a full 1-deep stage: the new entry replaces the old one in the same edge (no bubble).
- Reset mid-operation: in-flight entries are lost; state returns to RUN regardless of DRAIN/HALTED.

Decomposition:
- Shared package holds:
  - default MATCH_LIST constant;
  - HALT_OPCODE constant;
  - state encoding RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
- One sub-module, opcode_match_vec (combinational compare of an opcode against the parametrised list, returning the any-match bit and the lowest index).
- The pipeline registers and FSM live in the top module.

Test Plan:
- Reset, then stream 5'b11011, 5'b11111, 5'b00101 with out_ready=1, PIPE_DEPTH=1 -> out_alu_src2 = 1,1,0; out_match_idx = 0,5,0; src2_count=2; one output per cycle after 1-cycle latency.
- PIPE_DEPTH=2, out_ready=0 for 4 cycles with continuous in_valid -> exactly 2 accepted, then in_ready=0; out_* held stable; out_ready=1 releases both in order.
- Accept HALT_OPCODE followed by in_valid on 5'b11100 -> in_ready=0 until resume; halted=1 one cycle after the halt entry transfers out; resume -> 5'b11100 accepted next cycle.
- Flush with 2 entries in flight (PIPE_DEPTH=2) -> out_valid=0 the next cycle; flush-cycle input not accepted; src2_count unchanged unless an output transfer occurred in the flush cycle.
- CNT_W=2: 5 transfers of 5'b11010 -> src2_count ends at 3 (saturated, no wrap).
- Assert rst during DRAIN with entries in flight -> outputs at reset values immediately; state RUN; in_ready=1 after deassert.
